ps2_mouse_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_byte_rx.sv | 78 +++++++
 rtl/ps2_mouse_rx.sv | 76 +++++++
 tb/tb_ps2_mouse_rx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared bit-FSM state and packet field positions for the PS/2 mouse receiver
package ps2_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} bit_state_e;
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC = 3;
  localparam int XS = 4;
  localparam int YS = 5;
  localparam int XO = 6;
  localparam int YO = 7;
  localparam int PKT_BYTES = 3;
endpackage

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx: synchronises and filters the PS/2 lines and deframes bytes with parity, stop and timeout checks
module ps2_byte_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       tmo_en,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       idle,
  output logic [7:0] byte_data
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] cs, ds;
  logic filt, strobe, par_ok;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  bit_state_e st;
  assign strobe = filt && !cs[1] && fcnt == FW'(FILTER_LEN - 1);
  assign idle = st == S_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      cs <= 2'b11;
      ds <= 2'b11;
      filt <= 1'b1;
      fcnt <= '0;
      tcnt <= '0;
      st <= S_IDLE;
      bitn <= '0;
      sh <= '0;
      par_ok <= 1'b0;
      byte_valid <= 1'b0;
      byte_err <= 1'b0;
      byte_data <= '0;
    end else begin
      cs <= {cs[0], ps2_clk_i};
      ds <= {ds[0], ps2_data_i};
      fcnt <= cs[1] == filt || fcnt == FW'(FILTER_LEN - 1) ? '0 : fcnt + 1'b1;
      filt <= cs[1] != filt && fcnt == FW'(FILTER_LEN - 1) ? cs[1] : filt;
      byte_valid <= 1'b0;
      byte_err <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (st)
          S_IDLE: if (!ds[1]) begin
            st <= S_DATA;
            bitn <= '0;
          end
          S_DATA: begin
            sh <= {ds[1], sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) st <= S_PAR;
          end
          S_PAR: begin
            par_ok <= ^{sh, ds[1]};
            st <= S_STOP;
          end
          default: begin
            st <= S_IDLE;
            if (ds[1] && par_ok) begin
              byte_valid <= 1'b1;
              byte_data <= sh;
            end else byte_err <= 1'b1;
          end
        endcase
      end else if (tmo_en && tcnt == TW'(TIMEOUT - 1)) begin
        st <= S_IDLE;
        tcnt <= '0;
        byte_err <= 1'b1;
      end else tcnt <= tmo_en ? tcnt + 1'b1 : '0;
    end
endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: assembles PS/2 mouse packets into a clamped absolute cursor position and button state
module ps2_mouse_rx import ps2_pkg::*; #(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [15:0] mouse_x,
  output logic [15:0] mouse_y,
  output logic [7:0]  key_down,
  output logic        pkt_valid,
  output logic        err
);
  logic rx_valid, rx_err, rx_idle;
  logic [7:0] rx_data, b0, b1;
  logic [1:0] idx;
  logic signed [16:0] dx, dy, xs, ys;
  logic [15:0] nx, ny;
  ps2_byte_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .tmo_en(!rx_idle || idx != 2'd0),
    .byte_valid(rx_valid),
    .byte_err(rx_err),
    .idle(rx_idle),
    .byte_data(rx_data)
  );
  always_comb begin
    dx = b0[XO] ? '0 : {{8{b0[XS]}}, b0[XS], b1};
    dy = b0[YO] ? '0 : {{8{b0[YS]}}, b0[YS], rx_data};
    xs = signed'({1'b0, mouse_x}) + dx;
    ys = signed'({1'b0, mouse_y}) - dy;
    nx = xs[16] ? '0 : xs > 17'(X_MAX) ? 16'(X_MAX) : xs[15:0];
    ny = ys[16] ? '0 : ys > 17'(Y_MAX) ? 16'(Y_MAX) : ys[15:0];
  end
  always_ff @(posedge clk)
    if (rst) begin
      mouse_x <= 16'((X_MAX + 1) / 2);
      mouse_y <= 16'((Y_MAX + 1) / 2);
      key_down <= '0;
      pkt_valid <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      pkt_valid <= 1'b0;
      err <= 1'b0;
      if (rx_err) begin
        idx <= '0;
        err <= 1'b1;
      end else if (rx_valid) begin
        if (idx == 2'd0) begin
          if (rx_data[SYNC]) begin
            b0 <= rx_data;
            idx <= 2'd1;
          end else err <= 1'b1;
        end else if (idx != 2'(PKT_BYTES - 1)) begin
          b1 <= rx_data;
          idx <= idx + 1'b1;
        end else begin
          mouse_x <= nx;
          mouse_y <= ny;
          key_down <= {5'b0, b0[BTN_M], b0[BTN_R], b0[BTN_L]};
          pkt_valid <= 1'b1;
          idx <= '0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: directed PS/2 packet vectors against hand-computed cursor, button and pulse results
module tb_ps2_mouse_rx;
  localparam int TMO = 1000;
  localparam int H = 12;
  logic clk = 1'b0, rst = 1'b1, pc = 1'b1, pd = 1'b1;
  logic [15:0] mouse_x, mouse_y;
  logic [7:0] key_down;
  logic pkt_valid, err;
  int n_tests = 0, n_fail = 0, pv_n = 0, err_n = 0, both_n = 0, pv0 = 0, err0 = 0;
  always #5 clk = ~clk;
  ps2_mouse_rx #(.X_MAX(639), .Y_MAX(479), .FILTER_LEN(8), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_i(pc),
    .ps2_data_i(pd),
    .mouse_x(mouse_x),
    .mouse_y(mouse_y),
    .key_down(key_down),
    .pkt_valid(pkt_valid),
    .err(err)
  );
  always @(posedge clk) begin
    if (pkt_valid) pv_n <= pv_n + 1;
    if (err) err_n <= err_n + 1;
    if (pkt_valid && err) both_n <= both_n + 1;
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mark();
    pv0 = pv_n;
    err0 = err_n;
  endtask
  task automatic expect_st(string tag, int x, int y, int k, int dpv, int derr);
    cyc(4);
    check({tag, ".x"}, 32'(mouse_x), 32'(x));
    check({tag, ".y"}, 32'(mouse_y), 32'(y));
    check({tag, ".key"}, 32'(key_down), 32'(k));
    check({tag, ".pv"}, 32'(pv_n - pv0), 32'(dpv));
    check({tag, ".err"}, 32'(err_n - err0), 32'(derr));
    mark();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    mark();
  endtask
  task automatic send_bit(logic d);
    pd = d;
    cyc(H);
    pc = 1'b0;
    cyc(H);
    pc = 1'b1;
  endtask
  task automatic send_byte(logic [7:0] b, logic [1:0] bad = 2'b00);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad[0]);
    send_bit(~bad[1]);
    pd = 1'b1;
    cyc(H);
  endtask
  task automatic send_pkt(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask
  initial begin
    do_reset();
    cyc(50);
    expect_st("reset", 320, 240, 0, 0, 0);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("basic", 325, 237, 1, 1, 0);
    do_reset();
    send_pkt(8'h38, 8'hF6, 8'hFB);
    expect_st("neg", 310, 245, 0, 1, 0);
    do_reset();
    send_pkt(8'h18, 8'h01, 8'h00);
    expect_st("xlo1", 65, 240, 0, 1, 0);
    send_pkt(8'h18, 8'h01, 8'h00);
    expect_st("xlo2", 0, 240, 0, 1, 0);
    send_pkt(8'h18, 8'h01, 8'h00);
    expect_st("xlo3", 0, 240, 0, 1, 0);
    send_pkt(8'h08, 8'h00, 8'hFF);
    expect_st("ylo1", 0, 0, 0, 1, 0);
    send_pkt(8'h08, 8'h00, 8'hFF);
    expect_st("ylo2", 0, 0, 0, 1, 0);
    send_pkt(8'h28, 8'h00, 8'h01);
    expect_st("yhi1", 0, 255, 0, 1, 0);
    send_pkt(8'h28, 8'h00, 8'h01);
    expect_st("yhi2", 0, 479, 0, 1, 0);
    send_pkt(8'h08, 8'hFF, 8'h00);
    expect_st("xhi1", 255, 479, 0, 1, 0);
    send_pkt(8'h08, 8'hFF, 8'h00);
    expect_st("xhi2", 510, 479, 0, 1, 0);
    send_pkt(8'h08, 8'hFF, 8'h00);
    expect_st("xhi3", 639, 479, 0, 1, 0);
    do_reset();
    send_byte(8'h09);
    send_byte(8'h05, 2'b01);
    expect_st("badpar", 320, 240, 0, 0, 1);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("badpar.next", 325, 237, 1, 1, 0);
    send_byte(8'h09);
    send_byte(8'h05, 2'b10);
    expect_st("badstop", 325, 237, 1, 0, 1);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("badstop.next", 330, 234, 1, 1, 0);
    send_byte(8'h00);
    expect_st("sync", 330, 234, 1, 0, 1);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("sync.next", 335, 231, 1, 1, 0);
    send_byte(8'h09);
    cyc(TMO + 50);
    expect_st("tmo", 335, 231, 1, 0, 1);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("tmo.next", 340, 228, 1, 1, 0);
    send_pkt(8'h0E, 8'h00, 8'h00);
    expect_st("btns", 340, 228, 6, 1, 0);
    send_pkt(8'h49, 8'h10, 8'h00);
    expect_st("ovf", 340, 228, 1, 1, 0);
    send_byte(8'h09);
    send_byte(8'h05);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(TMO + 50);
    expect_st("rstmid", 320, 240, 0, 0, 0);
    send_pkt(8'h09, 8'h05, 8'h03);
    expect_st("rstmid.next", 325, 237, 1, 1, 0);
    check("pv_err_overlap", 32'(both_n), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
